// File: rtl/bpsk_demodulator_top.sv
// Coherent BPSK demodulator: multiplies each received sample by the LUT carrier,
// integrates over one symbol and emits a hard bit plus the signed correlation.
module bpsk_demodulator_top #(
    parameter int SAMPLE_W           = 16,
    parameter int CARRIER_N          = 64,
    parameter int PERIODS_PER_SYMBOL = 4,
    parameter int ACC_W              = 2*SAMPLE_W + $clog2(CARRIER_N*PERIODS_PER_SYMBOL)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              sync,
    input  logic signed [SAMPLE_W-1:0]        in,
    output logic [$clog2(CARRIER_N)-1:0]      cosine_lu,
    input  logic signed [SAMPLE_W-1:0]        carrier,
    output logic                              out,
    output logic signed [ACC_W-1:0]           out_soft,
    output logic                              out_valid
);

    localparam int PH_W = $clog2(CARRIER_N);
    localparam int PD_W = (PERIODS_PER_SYMBOL > 1) ? $clog2(PERIODS_PER_SYMBOL) : 1;
    localparam int PR_W = 2*SAMPLE_W;
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(CARRIER_N - 1);
    localparam logic [PD_W-1:0] PD_MAX = PD_W'(PERIODS_PER_SYMBOL - 1);

    logic [PH_W-1:0]         phase_q, phase_d, cur_phase;
    logic [PD_W-1:0]         period_q, period_d, cur_period;
    logic                    first_d, last_d;
    logic signed [PR_W-1:0]  prod_d;

    logic                    vld_p1_q, first_p1_q, last_p1_q;
    logic signed [PR_W-1:0]  prod_p1_q;

    logic signed [ACC_W-1:0] acc_q, acc_sum;
    logic                    out_q, out_valid_q;
    logic signed [ACC_W-1:0] out_soft_q;
    logic                    take_p1;

    // sync overrides the counters combinationally so the sample on the sync cycle is phase 0
    always_comb begin
        cur_phase  = sync ? '0 : phase_q;
        cur_period = sync ? '0 : period_q;
        first_d    = (cur_phase == '0) && (cur_period == '0);
        last_d     = (cur_phase == PH_MAX) && (cur_period == PD_MAX);
        phase_d    = cur_phase;
        period_d   = cur_period;
        if (en) begin
            if (cur_phase == PH_MAX) begin
                phase_d  = '0;
                period_d = (cur_period == PD_MAX) ? '0 : cur_period + PD_W'(1);
            end else begin
                phase_d  = cur_phase + PH_W'(1);
            end
        end
    end

    assign prod_d  = PR_W'(in) * PR_W'(carrier);
    assign take_p1 = vld_p1_q && !sync;
    assign acc_sum = first_p1_q ? ACC_W'(prod_p1_q) : acc_q + ACC_W'(prod_p1_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= '0;
            period_q    <= '0;
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            prod_p1_q   <= '0;
            acc_q       <= '0;
            out_q       <= 1'b0;
            out_soft_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            period_q <= period_d;

            // stage 1: product of sample and carrier, tagged with symbol position
            vld_p1_q <= en;
            if (en) begin
                prod_p1_q  <= prod_d;
                first_p1_q <= first_d;
                last_p1_q  <= last_d;
            end

            // stage 2: integrate, and on the last product of a symbol issue the decision
            out_valid_q <= take_p1 && last_p1_q;
            if (take_p1) begin
                acc_q <= acc_sum;
                if (last_p1_q) begin
                    out_soft_q <= acc_sum;
                    out_q      <= ~acc_sum[ACC_W-1];
                end
            end
        end
    end

    assign cosine_lu = phase_q;
    assign out       = out_q;
    assign out_soft  = out_soft_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bpsk_demodulator_top.sv
// Directed bench for bpsk_demodulator_top: 8-entry carrier LUT, 2 periods per symbol.
module tb_bpsk_demodulator_top;

    localparam int SW = 16;
    localparam int CN = 8;
    localparam int PP = 2;
    localparam int AW = 2*SW + $clog2(CN*PP);
    localparam longint FULL_SQ = 7998792;   // 2 * (2*1000^2 + 4*707^2)
    localparam longint PART_SQ = 7498641;   // 707^2 + (3999396 - 1000^2) + 3999396

    logic                 clk = 1'b0;
    logic                 rst, en, sync;
    logic signed [SW-1:0] din, carrier;
    logic [2:0]           cosine_lu;
    logic                 dout;
    logic signed [AW-1:0] out_soft;
    logic                 out_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int lut [8]  = '{1000, 707, 0, -707, -1000, -707, 0, 707};

    logic   q_out [$];
    longint q_soft[$];
    int     q_cyc [$];

    bpsk_demodulator_top #(
        .SAMPLE_W(SW), .CARRIER_N(CN), .PERIODS_PER_SYMBOL(PP), .ACC_W(AW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .in(din),
        .cosine_lu(cosine_lu), .carrier(carrier),
        .out(dout), .out_soft(out_soft), .out_valid(out_valid)
    );

    assign carrier = SW'(lut[cosine_lu]);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            q_out.push_back(dout);
            q_soft.push_back(longint'(out_soft));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // mode 0: zero, 1: +carrier (bit 1), 2: -carrier (bit 0)
    task automatic drive(input logic e, input logic s, input int mode);
        int c;
        c    = lut[cosine_lu];
        en   = e;
        sync = s;
        din  = (mode == 1) ? SW'(c) : (mode == 2) ? SW'(-c) : '0;
        last_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic symbol(input int mode, input logic sy);
        for (int i = 0; i < 16; i++) drive(1'b1, sy && (i == 0), mode);
    endtask

    task automatic clear_q;
        q_out.delete();
        q_soft.delete();
        q_cyc.delete();
    endtask

    initial begin
        int lc;
        int f;
        int s;
        int lcs[5];
        int bits[5];
        bits = '{1, 0, 1, 1, 0};

        rst = 1'b1; en = 1'b0; sync = 1'b0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_valid", out_valid, 0);
        chk_eq("rst_out", dout, 0);
        chk_eq("rst_soft", out_soft, 0);
        chk_eq("rst_lu", cosine_lu, 0);
        rst = 1'b0;
        idle(2);

        clear_q();
        symbol(1, 1'b1);
        lc = last_cyc;
        idle(4);
        chk_eq("pos_count", q_out.size(), 1);
        if (q_out.size() == 1) begin
            chk_eq("pos_out", q_out[0], 1);
            chk_eq("pos_soft", q_soft[0], FULL_SQ);
            chk_eq("pos_lat", q_cyc[0], lc + 2);
        end

        clear_q();
        symbol(0, 1'b0);
        idle(4);
        chk_eq("zero_count", q_out.size(), 1);
        if (q_out.size() == 1) begin
            chk_eq("zero_out", q_out[0], 1);
            chk_eq("zero_soft", q_soft[0], 0);
        end

        clear_q();
        for (int b = 0; b < 5; b++) begin
            symbol(bits[b] == 1 ? 1 : 2, b == 0);
            lcs[b] = last_cyc;
        end
        idle(4);
        chk_eq("loop_count", q_out.size(), 5);
        if (q_out.size() == 5) begin
            for (int b = 0; b < 5; b++) begin
                chk_eq($sformatf("loop_out%0d", b), q_out[b], bits[b]);
                chk_eq($sformatf("loop_soft%0d", b), q_soft[b],
                       bits[b] == 1 ? FULL_SQ : -FULL_SQ);
                chk_eq($sformatf("loop_lat%0d", b), q_cyc[b], lcs[b] + 2);
            end
        end

        clear_q();
        f = cyc;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) begin
                idle(5);
                chk_eq("gate_hold_lu", cosine_lu, 6);
            end
            drive(1'b1, i == 0, 1);
        end
        idle(4);
        chk_eq("gate_count", q_out.size(), 1);
        if (q_out.size() == 1) begin
            chk_eq("gate_soft", q_soft[0], FULL_SQ);
            chk_eq("gate_lat", q_cyc[0], f + 22);
        end

        clear_q();
        for (int i = 0; i < 9; i++) drive(1'b1, i == 0, 1);
        chk_eq("msync_lu_pre", cosine_lu, 1);
        drive(1'b1, 1'b1, 1);
        s = last_cyc;
        chk_eq("msync_lu_post", cosine_lu, 1);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1);
        idle(4);
        chk_eq("msync_count", q_out.size(), 1);
        if (q_out.size() == 1) begin
            chk_eq("msync_out", q_out[0], 1);
            chk_eq("msync_soft", q_soft[0], PART_SQ);
            chk_eq("msync_lat", q_cyc[0], s + 17);
        end

        clear_q();
        for (int i = 0; i < 15; i++) drive(1'b1, i == 0, 1);
        drive(1'b1, 1'b1, 1);
        idle(3);
        chk_eq("slast_none", q_out.size(), 0);
        for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 1);
        idle(4);
        chk_eq("slast_count", q_out.size(), 1);
        if (q_out.size() == 1) chk_eq("slast_soft", q_soft[0], PART_SQ);

        clear_q();
        for (int i = 0; i < 7; i++) drive(1'b1, i == 0, 2);
        #2 rst = 1'b1;
        #1;
        chk_eq("arst_valid", out_valid, 0);
        chk_eq("arst_out", dout, 0);
        chk_eq("arst_soft", out_soft, 0);
        chk_eq("arst_lu", cosine_lu, 0);
        en = 1'b0;
        sync = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 2);
        idle(6);
        chk_eq("arst_stale", q_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
